keypad_scan_engine: RTL and testbench

Parametrised matrix-keypad scanner: successor to the fixed 4x4 keypad scanner. Supports any row/column count, frame-based debounce, press/release events, multi-key rejection and optional auto-repeat. Drives the keypad rows and returns a key code plus single-cycle event strobes to the control module (CLCD/RTC UI). Column inputs are pulled up; a pressed key pulls its column low while its row is driven low.

---
 rtl/keypad_scan_engine.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scan_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_engine.sv
// rtl/keypad_scan_engine.sv - parametrised matrix keypad scanner with debounce, multi-key rejection and auto-repeat
module keypad_scan_engine #(
    parameter int P_ROWS         = 4,
    parameter int P_COLS         = 4,
    parameter int P_TICK         = 100_000,
    parameter int P_DEBOUNCE     = 3,
    parameter int P_REPEAT_EN    = 0,
    parameter int P_REPEAT_DELAY = 50,
    parameter int P_REPEAT_RATE  = 10,
    localparam int CW            = $clog2(P_ROWS * P_COLS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [P_COLS-1:0] i_col,
    output logic [P_ROWS-1:0] o_row,
    output logic [CW-1:0]     o_key_code,
    output logic              o_key_valid,
    output logic              o_key_repeat,
    output logic              o_key_release,
    output logic              o_key_held,
    output logic              o_multi
);
    localparam int TW = (P_TICK > 1) ? $clog2(P_TICK) : 1;
    localparam int RW = (P_ROWS > 1) ? $clog2(P_ROWS) : 1;
    localparam int HW = $clog2(P_REPEAT_DELAY + 1);
    localparam int PW = $clog2(P_REPEAT_RATE + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [RW-1:0] row_idx;
    logic [1:0]    acc_cnt;
    logic [CW-1:0] acc_code;
    logic [CW-1:0] cand;
    logic [3:0]    db_cnt;
    logic [3:0]    rel_cnt;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] rep_cnt;

    logic [1:0]    row_cnt;
    logic [1:0]    frm_cnt;
    logic [CW-1:0] row_col;
    logic [CW-1:0] frm_code;
    logic          sample;
    logic          frame_end;
    logic          frm_single;
    logic          frm_multi;

    always_comb begin
        for (int r = 0; r < P_ROWS; r++) begin
            o_row[r] = (row_idx != RW'(r));
        end
    end

    // Hit counts saturate at 2: only none / one / many matters for the frame verdict.
    always_comb begin
        row_cnt = 2'd0;
        row_col = '0;
        for (int c = P_COLS - 1; c >= 0; c--) begin
            if (!i_col[c]) begin
                row_col = CW'(c);
                if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
            end
        end
        frm_cnt  = acc_cnt;
        frm_code = acc_code;
        if (row_cnt == 2'd2 || acc_cnt == 2'd2 || (row_cnt == 2'd1 && acc_cnt == 2'd1)) begin
            frm_cnt = 2'd2;
        end else if (row_cnt == 2'd1) begin
            frm_cnt  = 2'd1;
            frm_code = CW'(row_idx) * CW'(P_COLS) + row_col;
        end
    end

    assign sample     = (tick == TW'(P_TICK / 2));
    assign frame_end  = sample && (row_idx == RW'(P_ROWS - 1));
    assign frm_single = (frm_cnt == 2'd1);
    assign frm_multi  = (frm_cnt == 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick          <= '0;
            row_idx       <= '0;
            acc_cnt       <= 2'd0;
            acc_code      <= '0;
            state         <= S_IDLE;
            cand          <= '0;
            db_cnt        <= 4'd0;
            rel_cnt       <= 4'd0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            o_key_code    <= '0;
            o_key_valid   <= 1'b0;
            o_key_repeat  <= 1'b0;
            o_key_release <= 1'b0;
            o_key_held    <= 1'b0;
            o_multi       <= 1'b0;
        end else begin
            o_key_valid   <= 1'b0;
            o_key_repeat  <= 1'b0;
            o_key_release <= 1'b0;

            if (tick == TW'(P_TICK - 1)) begin
                tick    <= '0;
                row_idx <= (row_idx == RW'(P_ROWS - 1)) ? '0 : row_idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end

            if (sample && !frame_end) begin
                acc_cnt  <= frm_cnt;
                acc_code <= frm_code;
            end

            if (frame_end) begin
                acc_cnt  <= 2'd0;
                acc_code <= '0;
                o_multi  <= frm_multi;
                case (state)
                    S_IDLE: begin
                        if (frm_single) begin
                            cand   <= frm_code;
                            db_cnt <= 4'd1;
                            if (P_DEBOUNCE == 1) begin
                                state       <= S_HELD;
                                o_key_code  <= frm_code;
                                o_key_valid <= 1'b1;
                                o_key_held  <= 1'b1;
                                hold_cnt    <= '0;
                                rep_cnt     <= '0;
                                rel_cnt     <= 4'd0;
                            end else begin
                                state <= S_PRESS_DB;
                            end
                        end
                    end
                    S_PRESS_DB: begin
                        if (frm_single && frm_code == cand) begin
                            if (db_cnt + 4'd1 == 4'(P_DEBOUNCE)) begin
                                state       <= S_HELD;
                                o_key_code  <= cand;
                                o_key_valid <= 1'b1;
                                o_key_held  <= 1'b1;
                                hold_cnt    <= '0;
                                rep_cnt     <= '0;
                                rel_cnt     <= 4'd0;
                            end else begin
                                db_cnt <= db_cnt + 4'd1;
                            end
                        end else if (frm_single) begin
                            cand   <= frm_code;
                            db_cnt <= 4'd1;
                        end else begin
                            state  <= S_IDLE;
                            db_cnt <= 4'd0;
                        end
                    end
                    S_HELD: begin
                        if (frm_single && frm_code == o_key_code) begin
                            rel_cnt <= 4'd0;
                            // hold_cnt parks at the delay; rep_cnt then paces the repeats
                            if (hold_cnt != HW'(P_REPEAT_DELAY)) begin
                                hold_cnt <= hold_cnt + HW'(1);
                                rep_cnt  <= '0;
                                if (hold_cnt + HW'(1) == HW'(P_REPEAT_DELAY) && P_REPEAT_EN != 0) begin
                                    o_key_valid  <= 1'b1;
                                    o_key_repeat <= 1'b1;
                                end
                            end else if (rep_cnt + PW'(1) == PW'(P_REPEAT_RATE)) begin
                                rep_cnt <= '0;
                                if (P_REPEAT_EN != 0) begin
                                    o_key_valid  <= 1'b1;
                                    o_key_repeat <= 1'b1;
                                end
                            end else begin
                                rep_cnt <= rep_cnt + PW'(1);
                            end
                        end else if (frm_multi) begin
                            rel_cnt <= 4'd0;
                        end else if (rel_cnt + 4'd1 == 4'(P_DEBOUNCE)) begin
                            state         <= S_IDLE;
                            o_key_release <= 1'b1;
                            o_key_held    <= 1'b0;
                            rel_cnt       <= 4'd0;
                            db_cnt        <= 4'd0;
                        end else begin
                            rel_cnt <= rel_cnt + 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_engine.sv
// tb/tb_keypad_scan_engine.sv - scoreboard bench for keypad_scan_engine
module tb_keypad_scan_engine;
    localparam int T      = 8;
    localparam int K_PRESS = 0;
    localparam int K_REP   = 1;
    localparam int K_REL   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] keys_a = '0;
    logic [15:0] keys_r = '0;
    logic [14:0] keys_n = '0;

    logic [3:0] col_a, row_a, code_a, col_r, row_r, code_r;
    logic [4:0] col_n;
    logic [2:0] row_n;
    logic [3:0] code_n;
    logic va, rpa, rla, hda, mua;
    logic vr, rpr, rlr, hdr, mur;
    logic vn, rpn, rln, hdn, mun;

    keypad_scan_engine #(.P_ROWS(4), .P_COLS(4), .P_TICK(T), .P_DEBOUNCE(2), .P_REPEAT_EN(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_col(col_a), .o_row(row_a), .o_key_code(code_a),
        .o_key_valid(va), .o_key_repeat(rpa), .o_key_release(rla), .o_key_held(hda), .o_multi(mua));
    keypad_scan_engine #(.P_ROWS(4), .P_COLS(4), .P_TICK(T), .P_DEBOUNCE(2), .P_REPEAT_EN(1),
                         .P_REPEAT_DELAY(4), .P_REPEAT_RATE(2)) dut_r (
        .i_clk(clk), .i_reset(rst), .i_col(col_r), .o_row(row_r), .o_key_code(code_r),
        .o_key_valid(vr), .o_key_repeat(rpr), .o_key_release(rlr), .o_key_held(hdr), .o_multi(mur));
    keypad_scan_engine #(.P_ROWS(3), .P_COLS(5), .P_TICK(T), .P_DEBOUNCE(2), .P_REPEAT_EN(0)) dut_n (
        .i_clk(clk), .i_reset(rst), .i_col(col_n), .o_row(row_n), .o_key_code(code_n),
        .o_key_valid(vn), .o_key_repeat(rpn), .o_key_release(rln), .o_key_held(hdn), .o_multi(mun));

    // Switch matrix: a column reads low when a pressed key sits on the currently driven row.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            col_a[c] = 1'b1;
            col_r[c] = 1'b1;
            for (int r = 0; r < 4; r++) begin
                if (!row_a[r] && keys_a[r*4+c]) col_a[c] = 1'b0;
                if (!row_r[r] && keys_r[r*4+c]) col_r[c] = 1'b0;
            end
        end
    end
    always_comb begin
        for (int c = 0; c < 5; c++) begin
            col_n[c] = 1'b1;
            for (int r = 0; r < 3; r++) begin
                if (!row_n[r] && keys_n[r*5+c]) col_n[c] = 1'b0;
            end
        end
    end

    typedef struct {
        int id;
        int kind;
        int code;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event lands one cycle after the last-row sample edge of frame f.
    task automatic push(input int id, input int kind, input int code, input int rows, input int f);
        exp_t e;
        e.id   = id;
        e.kind = kind;
        e.code = code;
        e.cyc  = f * rows * T + (rows - 1) * T + T / 2 + 1;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int id, input logic v, input logic rp, input logic rl,
                       input logic [3:0] code, input logic held);
        exp_t e;
        int kind;
        if (v && rl) begin
            n_cmp++;
            n_fail++;
            $display("FAIL valid_and_release dut=%0d cyc=%0d", id, cyc);
        end
        if (v || rl) begin
            n_cmp++;
            kind = rl ? K_REL : (rp ? K_REP : K_PRESS);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event dut=%0d kind=%0d code=%0d cyc=%0d", id, kind, code, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.id != id || e.kind != kind || e.code != int'(code) || e.cyc != cyc
                    || held != (kind != K_REL)) begin
                    n_fail++;
                    $display("FAIL event: got dut=%0d kind=%0d code=%0d cyc=%0d held=%0b expected dut=%0d kind=%0d code=%0d cyc=%0d held=%0b",
                             id, kind, code, cyc, held, e.id, e.kind, e.code, e.cyc, e.kind != K_REL);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, va, rpa, rla, code_a, hda);
        mon(1, vr, rpr, rlr, code_r, hdr);
        mon(2, vn, rpn, rln, code_n, hdn);
    end

    task automatic do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        keys_a = '0;
        keys_r = '0;
        keys_n = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic frames(input int n, input int rows);
        repeat (n * rows * T) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_row", row_a, 4'b1110);
        chk("rst_row_n", row_n, 3'b110);
        chk("rst_code", code_a, 0);
        chk("rst_held", hda, 0);
        chk("rst_multi", mua, 0);
        chk("rst_strobes", {va, rpa, rla}, 0);

        // single key code 9, then release
        push(0, K_PRESS, 9, 4, 1);
        push(0, K_REL, 9, 4, 6);
        keys_a = 16'h1 << 9;
        frames(3, 4);
        chk("a_held", hda, 1);
        chk("a_code", code_a, 9);
        frames(2, 4);
        keys_a = '0;
        frames(3, 4);
        chk("a_held_after_rel", hda, 0);
        chk("a_code_after_rel", code_a, 9);

        // bounce rejected, then a clean press of code 0
        do_reset();
        keys_a = 16'h1;
        frames(1, 4);
        keys_a = '0;
        frames(1, 4);
        keys_a = 16'h1;
        frames(1, 4);
        keys_a = '0;
        frames(2, 4);
        chk("bounce_held", hda, 0);
        push(0, K_PRESS, 0, 4, 6);
        push(0, K_REL, 0, 4, 8);
        keys_a = 16'h1;
        frames(2, 4);
        chk("bounce_then_press_held", hda, 1);
        keys_a = '0;
        frames(3, 4);

        // two keys in different rows
        do_reset();
        keys_a = (16'h1 << 6) | (16'h1 << 12);
        for (int f = 0; f < 4; f++) begin
            frames(1, 4);
            chk($sformatf("multi_f%0d", f), mua, 1);
        end
        keys_a = 16'h1 << 6;
        push(0, K_PRESS, 6, 4, 5);
        push(0, K_REL, 6, 4, 7);
        frames(1, 4);
        chk("multi_cleared", mua, 0);
        frames(1, 4);
        chk("multi_then_code", code_a, 6);
        chk("multi_then_held", hda, 1);
        keys_a = '0;
        frames(3, 4);

        // auto-repeat: 2 debounce frames + 12 held frames
        do_reset();
        keys_r = 16'h1 << 15;
        push(1, K_PRESS, 15, 4, 1);
        for (int f = 5; f <= 13; f += 2) push(1, K_REP, 15, 4, f);
        push(1, K_REL, 15, 4, 15);
        frames(14, 4);
        keys_r = '0;
        frames(3, 4);
        chk("rep_code", code_r, 15);
        chk("rep_held", hdr, 0);

        // reset while held
        do_reset();
        keys_a = 16'h1 << 9;
        push(0, K_PRESS, 9, 4, 1);
        frames(3, 4);
        chk("rh_held", hda, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rh_row", row_a, 4'b1110);
        chk("rh_code", code_a, 0);
        chk("rh_held_cleared", hda, 0);
        chk("rh_strobes", {va, rpa, rla, mua}, 0);
        rst = 1'b0;
        keys_a = '0;
        repeat (T) @(posedge clk);
        #1;
        chk("rh_row_next", row_a, 4'b1101);
        frames(4, 4);

        // non-square 3x5
        do_reset();
        chk("n_row0", row_n, 3'b110);
        repeat (T) @(posedge clk);
        #1 chk("n_row1", row_n, 3'b101);
        repeat (T) @(posedge clk);
        #1 chk("n_row2", row_n, 3'b011);
        repeat (T) @(posedge clk);
        #1 chk("n_row_wrap", row_n, 3'b110);
        do_reset();
        keys_n = 15'h1 << 14;
        push(2, K_PRESS, 14, 3, 1);
        push(2, K_REL, 14, 3, 5);
        frames(4, 3);
        keys_n = '0;
        chk("n_code", code_n, 14);
        chk("n_held", hdn, 1);
        frames(3, 3);
        chk("n_held_after_rel", hdn, 0);
        chk("n_code_after_rel", code_n, 14);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
